fp_result_stage: RTL and testbench
==================================

Name: fp_result_stage

Overview:
- Registered EX→WB stage directly downstream of the FP arithmetic unit.
- Captures the 32-bit FP result, 3-bit flag and destination register into a 2-entry skid buffer with a valid/ready handshake, so a writeback-port stall does not drop results.
- Maintains sticky FP status bits, a saturating NaN counter and a trap pulse for the CP1 status logic.

Parameters:
- DATA_W, 32, FP result width (IEEE-754 single).
- REG_W, 5, destination FP register index width.
- CNT_W, 8, width of the saturating NaN event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream result present this cycle.
- in_ready  output  1  stage can accept; equals (state != FULL), driven from registered state only.
- in_result  input  DATA_W  FP unit result.
- in_flag  input  3  {nan, zero, inf}; values 100 / 010 / 001 / 000.
- in_dest  input  REG_W  destination register.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes head.
- out_result  output  DATA_W  head result.
- out_flag  output  3  head flag.
- out_dest  output  REG_W  head destination.
- flush  input  1  drop all buffered entries (branch mispredict / exception).
- clear_sticky  input  1  clear the sticky status bits.
- trap_en  input  1  enable the NaN trap.
- sticky  output  3  accumulated {nan, zero, inf}.
- nan_count  output  CNT_W  saturating count of accepted NaN results.
- trap  output  1  one-cycle pulse.

Behaviour:
- Reset: state=EMPTY; out_valid=0; out_result=0, out_flag=0, out_dest=0; sticky=0; nan_count=0; trap=0; in_ready=0 during the reset cycle, 1 from the next cycle.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Two registers: head (drives the out_* ports) and skid.
- States:
  - EMPTY: accept → head=input, go to ONE.
  - ONE: accept & pop → head=input, stay in ONE. accept only → skid=input, go to FULL. pop only → go to EMPTY.
  - FULL: in_ready=0. pop → head=skid, go to ONE.
- Latency: 1 cycle from acceptance to out_valid when the stage is empty. Order is strictly FIFO. No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). Head data holds stable while out_valid=1 and out_ready=0.
- flush: state becomes EMPTY next cycle and any input presented in the same cycle is dropped. Sticky bits, nan_count and trap are not updated for a dropped input. flush overrides pop.
- Sticky: on accept, sticky_next = (clear_sticky ? 0 : sticky) | in_flag. Without accept, clear_sticky zeroes sticky. A simultaneous set wins over clear.
- nan_count: increments on accept with in_flag[2]=1 and saturates at 2^CNT_W-1 (no wrap). Cleared only by rst.
- trap: registered; equals 1 in the cycle after an accept with in_flag[2]=1 and trap_en=1, otherwise 0. The entry is still buffered normally.
- in_flag is taken as given; the stage does not reclassify in_result.
- Unknown flag encodings (multiple bits set) are ORed into sticky bit-wise.

Decomposition:
- Shared package fp_pkg:
  - FLAG_NAN=3'b100, FLAG_ZERO=3'b010, FLAG_INF=3'b001.
  - QNAN=32'h7FC00000, PINF=32'h7F800000.
  - State encoding EMPTY/ONE/FULL.
- The FP arithmetic unit's flag generation uses the same package constants.
- One natural sub-module: fp_skid_buffer, holding the handshake and the two data registers. The sticky, counter and trap logic stays in the top level.

Test Plan:
- Reset, then in_valid=1 with result 32'h40400000, flag 000, dest 3, and out_ready=1 → out_valid=1 next cycle with 40400000 / dest 3; sticky=000.
- out_ready=0 and three back-to-back inputs A, B, C → A and B accepted, in_ready=0 on the 3rd cycle so C is held; raise out_ready → outputs A, B, C in order with none lost or duplicated.
- Accept 7FC00000 with flag 100 and trap_en=1 → trap=1 for exactly one cycle, sticky=100, nan_count=1. Then clear_sticky together with a flag-010 accept → sticky=010.
- Stage FULL, assert flush together with in_valid → out_valid=0 next cycle; the dropped input does not affect sticky or nan_count; in_ready=1.
- With CNT_W=2, four NaN accepts → nan_count reads 1, 2, 3, 3 (saturates).
- rst asserted while FULL → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP constants, flag encodings and the result-stage buffer state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package fp_pkg;

   // One-hot FP classification flags, bit order {nan, zero, inf}
   localparam logic [2:0] FLAG_NAN  = 3'b100;
   localparam logic [2:0] FLAG_ZERO = 3'b010;
   localparam logic [2:0] FLAG_INF  = 3'b001;

   // Canonical IEEE-754 single-precision special values
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   // Occupancy of the two-entry skid buffer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   // The nan bit is the MSB of the flag field
   function automatic logic flag_is_nan(input logic [2:0] flag);
      return flag[2];
   endfunction

endpackage

// File: rtl/fp_skid_buffer.sv
// Two-entry skid buffer (head + skid register) with valid/ready handshake and flush.
// Latency: 1 cycle from accept to out_valid when empty; strict FIFO order.
// Backpressure: in_ready depends only on registered state (and rst), never on out_ready.
module fp_skid_buffer
   import fp_pkg::*;
#(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         accept
);

   skid_state_e  state;
   logic [W-1:0] head;
   logic [W-1:0] skid;
   logic         pop;

   // Handshake qualifiers; a flushed input is never accepted
   assign in_ready  = (state != FULL) && !rst;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
   assign out_data  = head;

   // Occupancy FSM and data registers; flush wins over pop
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head  <= in_data;
                  state <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head <= in_data;
               end else if (accept) begin
                  skid  <= in_data;
                  state <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/fp_result_stage.sv
// EX->WB FP result stage: skid-buffered result/flag/dest plus sticky flags, NaN counter, trap.
// Latency: 1 cycle accept-to-output when empty; trap pulses the cycle after a NaN accept.
// Backpressure: holds up to two results under out_ready=0; in_ready drops only when full.
module fp_result_stage
   import fp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [2:0]        in_flag,
   input  logic [REG_W-1:0]  in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [2:0]        out_flag,
   output logic [REG_W-1:0]  out_dest,
   input  logic              flush,
   input  logic              clear_sticky,
   input  logic              trap_en,
   output logic [2:0]        sticky,
   output logic [CNT_W-1:0]  nan_count,
   output logic              trap
);

   localparam int              ENT_W   = DATA_W + 3 + REG_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [ENT_W-1:0] in_ent;
   logic [ENT_W-1:0] out_ent;
   logic             accept;
   logic             nan_accept;

   assign in_ent                            = {in_result, in_flag, in_dest};
   assign {out_result, out_flag, out_dest}  = out_ent;
   assign nan_accept                        = accept && flag_is_nan(in_flag);

   fp_skid_buffer #(
      .W (ENT_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_ent),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_ent),
      .accept    (accept)
   );

   // Sticky status: a same-cycle flag set takes priority over the clear
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky <= '0;
      end else if (accept) begin
         sticky <= (clear_sticky ? 3'b000 : sticky) | in_flag;
      end else if (clear_sticky) begin
         sticky <= '0;
      end
   end

   // Saturating count of accepted NaN results; only rst clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         nan_count <= '0;
      end else if (nan_accept && (nan_count != CNT_MAX)) begin
         nan_count <= nan_count + 1'b1;
      end
   end

   // One-cycle trap pulse following an enabled NaN accept
   always_ff @(posedge clk) begin
      if (rst) begin
         trap <= 1'b0;
      end else begin
         trap <= nan_accept && trap_en;
      end
   end

endmodule

// File: tb/tb_fp_result_stage.sv
module tb_fp_result_stage;
   import fp_pkg::*;

   localparam int DW   = 32;
   localparam int RW   = 5;
   localparam int CW   = 2;
   localparam int CMAX = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_result;
   logic [2:0]    in_flag;
   logic [RW-1:0] in_dest;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic [2:0]    out_flag;
   logic [RW-1:0] out_dest;
   logic          flush;
   logic          clear_sticky;
   logic          trap_en;
   logic [2:0]    sticky;
   logic [CW-1:0] nan_count;
   logic          trap;

   typedef struct packed {
      logic [31:0] r;
      logic [2:0]  f;
      logic [4:0]  d;
   } ent_t;

   ent_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   int         occ      = 0;
   logic [2:0] m_sticky = 3'b000;
   int         m_cnt    = 0;
   bit         m_trap   = 1'b0;
   bit         last_acc = 1'b0;

   fp_result_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_flag      (in_flag),
      .in_dest      (in_dest),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flag     (out_flag),
      .out_dest     (out_dest),
      .flush        (flush),
      .clear_sticky (clear_sticky),
      .trap_en      (trap_en),
      .sticky       (sticky),
      .nan_count    (nan_count),
      .trap         (trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every consumed head entry must match the oldest expected entry
   always @(negedge clk) begin : monitor
      ent_t e;
      if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected: got %h expected no output at %0t", out_result, $time);
         end else begin
            e = sb.pop_front();
            chk("out_result", out_result, e.r);
            chk("out_flag", {29'd0, out_flag}, {29'd0, e.f});
            chk("out_dest", {27'd0, out_dest}, {27'd0, e.d});
         end
      end
   end

   // One clock of stimulus: check status at the negedge, then advance the model at the edge
   task automatic step();
      bit exp_rdy, acc, pop;
      exp_rdy  = !rst && (occ < 2);
      acc      = in_valid && exp_rdy && !flush;
      pop      = (occ > 0) && out_ready;
      last_acc = acc;
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
      chk("sticky", {29'd0, sticky}, {29'd0, m_sticky});
      chk("nan_count", {30'd0, nan_count}, m_cnt);
      chk("trap", {31'd0, trap}, {31'd0, m_trap});
      @(posedge clk);
      if (rst) begin
         occ      = 0;
         m_sticky = 3'b000;
         m_cnt    = 0;
         m_trap   = 1'b0;
         sb.delete();
      end else begin
         m_trap = acc && in_flag[2] && trap_en;
         if (acc) m_sticky = (clear_sticky ? 3'b000 : m_sticky) | in_flag;
         else if (clear_sticky) m_sticky = 3'b000;
         if (acc && in_flag[2] && m_cnt < CMAX) m_cnt++;
         if (flush) begin
            occ = 0;
            sb.delete();
         end else begin
            occ = occ - (pop ? 1 : 0) + (acc ? 1 : 0);
            if (acc) sb.push_back(ent_t'{r: in_result, f: in_flag, d: in_dest});
         end
      end
      #1;
   endtask

   // Present one input until the model says it was accepted (bounded)
   task automatic send(input logic [31:0] r, input logic [2:0] f, input logic [4:0] d);
      in_valid  = 1'b1;
      in_result = r;
      in_flag   = f;
      in_dest   = d;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got no accept expected accept of %h", r);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_reset_data();
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_flag", {29'd0, out_flag}, 32'd0);
      chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
   endtask

   function automatic logic [2:0] rand_flag();
      case ($urandom_range(0, 5))
         0:       return FLAG_NAN;
         1:       return FLAG_ZERO;
         2:       return FLAG_INF;
         3:       return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flag = '0; in_dest = '0;
      out_ready = 1'b0; flush = 1'b0; clear_sticky = 1'b0; trap_en = 1'b0;
      idle(2);
      chk_reset_data();
      rst = 1'b0;

      // Basic transfer, 1-cycle latency
      out_ready = 1'b1;
      send(32'h4040_0000, 3'b000, 5'd3);
      idle(2);

      // Backpressure: A and B buffered, C held, then drained in order
      out_ready = 1'b0;
      send(32'hAAAA_0001, 3'b000, 5'd1);
      send(32'hBBBB_0002, 3'b000, 5'd2);
      in_valid = 1'b1; in_result = 32'hCCCC_0003; in_flag = 3'b000; in_dest = 5'd4;
      step();
      out_ready = 1'b1;
      send(32'hCCCC_0003, 3'b000, 5'd4);
      idle(4);

      // NaN with trap enabled, then clear_sticky with a zero result
      trap_en = 1'b1;
      send(QNAN, FLAG_NAN, 5'd7);
      idle(2);
      trap_en = 1'b0;
      clear_sticky = 1'b1;
      send(32'h0000_0000, FLAG_ZERO, 5'd8);
      clear_sticky = 1'b0;
      idle(2);

      // Flush while full, with a NaN input presented in the same cycle
      out_ready = 1'b0;
      send(PINF, FLAG_INF, 5'd9);
      send(32'h1234_5678, 3'b000, 5'd10);
      flush = 1'b1; in_valid = 1'b1; in_result = QNAN; in_flag = FLAG_NAN; in_dest = 5'd11;
      step();
      flush = 1'b0; in_valid = 1'b0;
      idle(2);

      // Counter saturation after a fresh reset
      rst = 1'b1; idle(1); rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(QNAN, FLAG_NAN, 5'(i));
      idle(2);

      // Reset while full
      out_ready = 1'b0;
      send(32'h3F80_0000, FLAG_INF, 5'd12);
      send(32'hBF80_0000, 3'b000, 5'd13);
      rst = 1'b1; step(); rst = 1'b0;
      chk_reset_data();
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_flag      = rand_flag();
         in_result    = in_flag[2] ? QNAN : $urandom;
         in_dest      = 5'($urandom_range(0, 31));
         out_ready    = ($urandom_range(0, 2) != 0);
         flush        = ($urandom_range(0, 24) == 0);
         clear_sticky = ($urandom_range(0, 9) == 0);
         trap_en      = $urandom_range(0, 1) == 1;
         rst          = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; clear_sticky = 1'b0; out_ready = 1'b1;
      idle(4);
      chk("drain_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
